// File: rtl/icache_assoc_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc_if
// Purpose  : Fetch-side and memory-side bus of the set-associative I-cache.
// Ports    : fetch_en/fetch_pc   fetch request into the cache
//            hit/inst_out        lookup result out of the cache
//            mem_req_*           block refill request out of the cache
//            mem_rsp_*           refill words into the cache
// Modports : slave  - the cache itself
//            master - the fetch unit / memory model driving the cache
// Revision : 1.0 - initial release
// ============================================================================
interface icache_assoc_if;
  logic        fetch_en;
  logic [31:0] fetch_pc;
  logic        hit;
  logic [31:0] inst_out;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport slave (
    input  fetch_en, fetch_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output hit, inst_out, mem_req_valid, mem_req_addr
  );

  modport master (
    output fetch_en, fetch_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  hit, inst_out, mem_req_valid, mem_req_addr
  );
endinterface
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Purpose  : WAYS-way set-associative instruction cache with combinational
//            lookup and a block refill engine (IDLE -> REQ -> FILL).
// Ports    : clk     sole clock, rising edge
//            rst_in  synchronous active-high reset (beats rdy_in and flush)
//            rdy_in  global enable; low freezes all state
//            flush   invalidate whole cache, abort any refill
//            bus     icache_assoc_if.slave (fetch lookup + memory refill)
// Revision : 1.0 - initial release
// ============================================================================
module icache_assoc #(
  parameter int WAYS        = 2,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_in,
  input  wire logic       rdy_in,
  input  wire logic       flush,
  icache_assoc_if.slave   bus
);

  localparam int OFF = $clog2(BLOCK_WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 32 - IDX - OFF - 2;
  localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2} state_t;

  state_t           state_q;
  logic             req_valid_q;
  logic [31:0]      addr_q;
  logic [WB-1:0]    victim_q;
  logic [OFF-1:0]   cnt_q;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG-1:0]   tag_q   [SETS][WAYS];
  logic [WB-1:0]    rr_q    [SETS];
  logic [31:0]      data_q  [WAYS][SETS][BLOCK_WORDS];

  logic [IDX-1:0]   lk_idx;
  logic [TAG-1:0]   lk_tag;
  logic [OFF-1:0]   lk_off;
  logic [IDX-1:0]   fill_idx;
  logic [TAG-1:0]   fill_tag;
  logic             hit_any;
  logic [31:0]      hit_data;
  logic [WB-1:0]    victim_d;
  logic             victim_found;
  logic [WB-1:0]    rr_next;
  logic             last_word;
  logic             unused_bits;

  assign lk_idx    = bus.fetch_pc[IDX+OFF+1:OFF+2];
  assign lk_tag    = bus.fetch_pc[31:IDX+OFF+2];
  assign lk_off    = bus.fetch_pc[OFF+1:2];
  assign fill_idx  = addr_q[IDX+OFF+1:OFF+2];
  assign fill_tag  = addr_q[31:IDX+OFF+2];
  assign last_word = (cnt_q == OFF'(BLOCK_WORDS - 1));
  assign rr_next   = (32'(rr_q[fill_idx]) == WAYS - 1) ? '0 : rr_q[fill_idx] + 1'b1;
  // Byte offset of fetch_pc and the block-offset bits of the refill address
  // carry no information for the cache.
  assign unused_bits = ^{bus.fetch_pc[1:0], addr_q[OFF+1:0]};

  // Tag compare across all ways of the indexed set. The refill victim had its
  // valid bit cleared when the miss was taken, so a partially written block
  // can never produce a hit.
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        hit_any  = 1'b1;
        hit_data = data_q[w][lk_idx][lk_off];
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    victim_d     = rr_q[lk_idx];
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[lk_idx][w]) begin
        victim_d     = w[WB-1:0];
        victim_found = 1'b1;
      end
    end
  end

  assign bus.hit           = bus.fetch_en & hit_any;
  assign bus.inst_out      = bus.hit ? hit_data : 32'd0;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = addr_q;

  // Refill FSM plus valid/tag/pointer state. Priority: reset, freeze, flush.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      victim_q    <= '0;
      cnt_q       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
      end
    end else if (rdy_in) begin
      if (flush) begin
        state_q     <= IDLE;
        req_valid_q <= 1'b0;
        cnt_q       <= '0;
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.fetch_en && !hit_any) begin
              addr_q                   <= {bus.fetch_pc[31:OFF+2], {(OFF+2){1'b0}}};
              victim_q                 <= victim_d;
              valid_q[lk_idx][victim_d] <= 1'b0;
              req_valid_q              <= 1'b1;
              state_q                  <= REQ;
            end
          end
          REQ: begin
            if (bus.mem_req_ready) begin
              req_valid_q <= 1'b0;
              cnt_q       <= '0;
              state_q     <= FILL;
            end
          end
          FILL: begin
            if (bus.mem_rsp_valid) begin
              cnt_q <= cnt_q + 1'b1;
              if (last_word) begin
                tag_q[fill_idx][victim_q]   <= fill_tag;
                valid_q[fill_idx][victim_q] <= 1'b1;
                rr_q[fill_idx]              <= rr_next;
                cnt_q                       <= '0;
                state_q                     <= IDLE;
              end
            end
          end
          default: begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Data array carries no reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (!rst_in && rdy_in && !flush && (state_q == FILL) && bus.mem_rsp_valid) begin
      data_q[victim_q][fill_idx][cnt_q] <= bus.mem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_assoc
// Purpose  : Directed self-checking bench for icache_assoc (2 ways, 16 sets,
//            4-word blocks). Inputs change on the falling edge; outputs are
//            sampled shortly after the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;
  logic clk;
  logic rst_in;
  logic rdy_in;
  logic flush;
  int   vec_cnt;
  int   err_cnt;

  icache_assoc_if bus ();

  icache_assoc #(.WAYS(2), .SETS(16), .BLOCK_WORDS(4)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Single-cycle lookup; fetch_en is dropped before the rising edge so a miss
  // in IDLE never launches a refill.
  task automatic probe(input string tag, input logic [31:0] pc,
                       input logic exp_hit, input logic [31:0] exp_inst);
    bus.fetch_en = 1'b1;
    bus.fetch_pc = pc;
    #1;
    chk({tag, "_hit"},  {31'd0, bus.hit}, {31'd0, exp_hit});
    chk({tag, "_inst"}, bus.inst_out, exp_inst);
    bus.fetch_en = 1'b0;
    tick();
  endtask

  // Launch a miss from IDLE and check the resulting refill request.
  task automatic start_miss(input string tag, input logic [31:0] pc, input logic [31:0] exp_addr);
    bus.fetch_en = 1'b1;
    bus.fetch_pc = pc;
    #1;
    chk({tag, "_miss"}, {31'd0, bus.hit}, 32'd0);
    tick();
    bus.fetch_en = 1'b0;
    chk({tag, "_reqv"}, {31'd0, bus.mem_req_valid}, 32'd1);
    chk({tag, "_addr"}, bus.mem_req_addr, exp_addr);
  endtask

  task automatic accept();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic words(input logic [31:0] d0, input int first, input int last);
    for (int i = first; i < last; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d0 + 32'(i);
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic fill(input string tag, input logic [31:0] pc, input logic [31:0] base,
                      input logic [31:0] d0);
    start_miss(tag, pc, base);
    accept();
    words(d0, 0, 4);
  endtask

  initial begin
    vec_cnt           = 0;
    err_cnt           = 0;
    rst_in            = 1'b1;
    rdy_in            = 1'b1;
    flush             = 1'b0;
    bus.fetch_en      = 1'b0;
    bus.fetch_pc      = 32'd0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
    tick();
    tick();
    rst_in = 1'b0;

    // Reset state
    chk("rst_reqv", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_addr", bus.mem_req_addr, 32'd0);
    probe("rst_look", 32'h0000_1008, 1'b0, 32'd0);

    // Cold miss, then hit on the installed block
    fill("cold", 32'h0000_1008, 32'h0000_1000, 32'hA0);
    probe("cold_hit", 32'h0000_1008, 1'b1, 32'hA2);
    probe("cold_w0",  32'h0000_1000, 1'b1, 32'hA0);

    // Conflict in set 0: third block evicts way 0 (0x1000)
    fill("c2", 32'h0000_2000, 32'h0000_2000, 32'hB0);
    fill("c3", 32'h0000_3000, 32'h0000_3000, 32'hC0);
    probe("c_1000", 32'h0000_1000, 1'b0, 32'd0);
    probe("c_2004", 32'h0000_2004, 1'b1, 32'hB1);
    probe("c_300c", 32'h0000_300C, 1'b1, 32'hC3);

    // Flush after two words: refill abandoned, late word ignored in IDLE
    start_miss("fl", 32'h0000_4000, 32'h0000_4000);
    accept();
    words(32'hD0, 0, 2);
    flush             = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hD2;
    bus.fetch_en      = 1'b1;
    bus.fetch_pc      = 32'h0000_7000;
    tick();
    flush             = 1'b0;
    bus.fetch_en      = 1'b0;
    bus.mem_rsp_data  = 32'hD3;
    #1;
    chk("fl_reqv", {31'd0, bus.mem_req_valid}, 32'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    chk("fl_noreq", {31'd0, bus.mem_req_valid}, 32'd0);
    probe("fl_4008", 32'h0000_4008, 1'b0, 32'd0);
    probe("fl_2000", 32'h0000_2000, 1'b0, 32'd0);
    fill("fl_re", 32'h0000_4000, 32'h0000_4000, 32'hD0);
    probe("fl_re_hit", 32'h0000_4008, 1'b1, 32'hD2);

    // Re-install 0x1000 for hit-under-miss
    fill("r1", 32'h0000_1000, 32'h0000_1000, 32'hA0);

    // Request held while ready low; fetch_pc wanders meanwhile
    start_miss("hold", 32'h0000_5014, 32'h0000_5010);
    for (int i = 0; i < 5; i++) begin
      bus.fetch_en = 1'b1;
      bus.fetch_pc = 32'h0000_9000 + 32'(i * 'h44);
      #1;
      chk("hold_reqv", {31'd0, bus.mem_req_valid}, 32'd1);
      chk("hold_addr", bus.mem_req_addr, 32'h0000_5010);
      tick();
    end
    bus.fetch_en = 1'b0;
    accept();
    chk("fill_reqv", {31'd0, bus.mem_req_valid}, 32'd0);
    words(32'hE0, 0, 1);
    // Word 1 held by memory across two frozen cycles
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hE1;
    rdy_in            = 1'b0;
    tick();
    tick();
    rdy_in = 1'b1;
    tick();
    bus.mem_rsp_valid = 1'b0;
    probe("hum_1004", 32'h0000_1004, 1'b1, 32'hA1);
    probe("hum_part", 32'h0000_5010, 1'b0, 32'd0);
    words(32'hE0, 2, 4);
    probe("e_5010", 32'h0000_5010, 1'b1, 32'hE0);
    probe("e_5014", 32'h0000_5014, 1'b1, 32'hE1);
    probe("e_501c", 32'h0000_501C, 1'b1, 32'hE3);

    // Set 0 full (way0=0x4000, way1=0x1000, pointer at way 0): victim hides
    start_miss("vic", 32'h0000_6000, 32'h0000_6000);
    probe("vic_4000", 32'h0000_4000, 1'b0, 32'd0);
    probe("vic_1000", 32'h0000_1000, 1'b1, 32'hA0);
    accept();
    words(32'hF0, 0, 1);

    // Reset during FILL
    rst_in            = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hF1;
    tick();
    rst_in            = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    chk("rf_reqv", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rf_addr", bus.mem_req_addr, 32'd0);
    probe("rf_1000", 32'h0000_1000, 1'b0, 32'd0);
    probe("rf_5010", 32'h0000_5010, 1'b0, 32'd0);
    probe("rf_6000", 32'h0000_6000, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 Parameter WAYS, default 2, associativity (power of two, 1..8).
REQ-002 Parameter SETS, default 16, sets per way (power of two, >=2).
REQ-003 Parameter BLOCK_WORDS, default 4, 32-bit words per block (power of two, >=2).
REQ-004 Derived: OFF=log2(BLOCK_WORDS), IDX=log2(SETS), TAG=32-IDX-OFF-2; pc[1:0] ignored.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_in  input  1  synchronous, active-high reset.
REQ-007 rdy_in  input  1  global enable; low freezes all state.
REQ-008 fetch_en  input  1  fetch request valid.
REQ-009 fetch_pc  input  32  fetch address.
REQ-010 flush  input  1  invalidate entire cache.
REQ-011 hit  output  1  fetch_pc hits this cycle, inst_out valid.
REQ-012 inst_out  output  32  instruction word at fetch_pc.
REQ-013 mem_req_valid  output  1  block refill request.
REQ-014 mem_req_addr  output  32  block-aligned refill address (low OFF+2 bits zero).
REQ-015 mem_req_ready  input  1  memory accepts request.
REQ-016 mem_rsp_valid  input  1  one refill word present.
REQ-017 mem_rsp_data  input  32  refill word, ascending offset order from offset 0.

Function
REQ-018 Lookup combinational: hit = fetch_en & any way valid with matching tag at index fetch_pc[IDX+OFF+1:OFF+2]; inst_out = word fetch_pc[OFF+1:2] of hitting way; inst_out = 0 when hit low.
REQ-019 FSM states IDLE, REQ, FILL; reset state IDLE.
REQ-020 IDLE: fetch_en & !hit & !flush -> latch block address and victim way, go REQ next cycle.
REQ-021 REQ: mem_req_valid=1, mem_req_addr stable; on mem_req_ready -> FILL, word counter = 0.
REQ-022 FILL: each mem_rsp_valid writes mem_rsp_data into victim data word [counter], counter+1; mem_rsp_valid outside FILL ignored.
REQ-023 Last word (counter = BLOCK_WORDS-1): write tag, set valid, advance replacement pointer, -> IDLE; hit possible the following cycle.
REQ-024 Victim: lowest-index invalid way in set; if all valid, per-set round-robin pointer (wraps WAYS-1 -> 0).
REQ-025 During REQ/FILL hit may still assert for other resident blocks; victim way reads as invalid until fill completes (no partial-block hits).
REQ-026 fetch_pc may change during REQ/FILL; in-flight refill completes to latched address regardless.
REQ-027 flush: all valid bits cleared next cycle, round-robin pointers zeroed; in REQ/FILL aborts refill -> IDLE, fill data not installed; flush has priority over every same-cycle event.
REQ-028 Memory responses for an aborted refill arriving after flush are ignored while in IDLE; a new REQ is not issued in the cycle flush is high.
REQ-029 rdy_in low: no FSM, counter, array or pointer update; outputs reflect frozen state; incoming mem_rsp_valid that cycle is dropped (memory holds until rdy_in high).

Reset
REQ-030 rst_in high: state IDLE, all valid bits, tags, pointers, counter cleared; mem_req_valid=0, hit=0, inst_out=0 next cycle.
REQ-031 Reset mid-REQ/FILL aborts refill; data arrays need not be cleared.
REQ-032 rst_in has priority over rdy_in and flush.

Verification (defaults WAYS=2, SETS=16, BLOCK_WORDS=4)
REQ-033 Cold miss: fetch 0x0000_1008 after reset -> hit=0, mem_req_addr=0x0000_1000; words 0xA0..0xA3 -> next cycle hit=1, inst_out=0xA2.
REQ-034 Conflict: fill 0x1000, 0x2000, 0x3000 (all set 0) -> 0x3000 replaces way 0 (0x1000 misses), 0x2000 still hits.
REQ-035 Flush mid-fill after 2 words of 0x4000 -> IDLE; later 0x4000 fetch misses and re-requests 0x4000.
REQ-036 mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable throughout; rdy_in low during FILL drops no accepted word.
REQ-037 Hit under miss: 0x1000 resident, fill of 0x5010 in progress, fetch 0x1004 -> hit=1 same cycle.
REQ-038 Reset during FILL -> mem_req_valid=0, all fetches miss next cycle.
